// File: rtl/pio_pkg.sv
// Shared types and limits for the PIO polling initiators.
package pio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } poll_state_t;

    localparam int POLL_DIV_W       = 24;
    localparam int MAX_READ_LATENCY = 4;

endpackage

// File: rtl/pio_poll_master.sv
// Avalon-MM read initiator that polls one PIO register at a fixed interval and
// forwards changed values on a valid/ready stream with a change pulse.
module pio_poll_master
    import pio_pkg::*;
#(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int POLL_ADDR    = 0,
    parameter int POLL_DIV     = 50000,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0] smp_data,
    output logic              smp_valid,
    input  logic              smp_ready,
    output logic              change_pulse,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int LAT_W = $clog2(MAX_READ_LATENCY);
    localparam logic [POLL_DIV_W-1:0] DIV_LAST = POLL_DIV_W'(POLL_DIV - 1);
    localparam logic [LAT_W-1:0]      LAT_LAST = LAT_W'(READ_LATENCY - 1);

    poll_state_t             state;
    poll_state_t             state_next;
    logic [POLL_DIV_W-1:0]   divider;
    logic [LAT_W-1:0]        lat_cnt;
    logic [DATA_W-1:0]       last;
    logic                    first_flag;
    logic                    capture;
    logic                    changed;

    assign avm_address = ADDR_W'(POLL_ADDR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The very first poll after reset skips the interval so a value is available at once.
    always_comb begin
        state_next = state;
        avm_read   = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (first_flag || divider == DIV_LAST)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divider <= '0;
            lat_cnt <= '0;
        end else begin
            if (state == IDLE && enable && state_next == IDLE) begin
                divider <= divider + 1'b1;
            end else begin
                divider <= '0;
            end
            if (state == WAIT && !capture) begin
                lat_cnt <= lat_cnt + 1'b1;
            end else begin
                lat_cnt <= '0;
            end
        end
    end

    assign changed = first_flag || (avm_readdata != last);

    // A fresh change always replaces the pending sample; overrun flags that the old one was lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last         <= '0;
            first_flag   <= 1'b1;
            smp_data     <= '0;
            smp_valid    <= 1'b0;
            change_pulse <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            change_pulse <= capture && changed;
            if (capture && changed) begin
                last       <= avm_readdata;
                smp_data   <= avm_readdata;
                smp_valid  <= 1'b1;
                first_flag <= 1'b0;
            end else if (smp_valid && smp_ready) begin
                smp_valid <= 1'b0;
            end
            if (capture && changed && smp_valid && !smp_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pio_poll_master.sv
// Randomised and directed bench for pio_poll_master with a PIO slave model and scoreboard.
module tb_pio_poll_master;

    localparam int ADDR_W    = 2;
    localparam int DATA_W    = 32;
    localparam int POLL_ADDR = 2;
    localparam int POLL_DIV  = 8;
    localparam int RL        = 3;
    localparam int PERIOD    = POLL_DIV + 1 + RL;

    logic              clk;
    logic              reset_n;
    logic              enable;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic [DATA_W-1:0] smp_data;
    logic              smp_valid;
    logic              smp_ready;
    logic              change_pulse;
    logic              overrun;
    logic              overrun_clr;

    int checkCount = 0;
    int passCount  = 0;
    int tb_cyc     = 0;

    pio_poll_master #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .POLL_ADDR(POLL_ADDR),
        .POLL_DIV(POLL_DIV),
        .READ_LATENCY(RL)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata),
        .smp_data(smp_data),
        .smp_valid(smp_valid),
        .smp_ready(smp_ready),
        .change_pulse(change_pulse),
        .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) tb_cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, tb_cyc);
        end else begin
            passCount++;
        end
    endtask

    // PIO slave: in_port sampled on the accepting edge, returned RL cycles later, junk otherwise.
    logic [DATA_W-1:0] in_port;
    logic [DATA_W-1:0] pipe [RL];
    int  stall_cfg  = 0;
    bit  stall_rand = 0;
    int  stall_left = 0;
    bit  in_req     = 0;

    always @(posedge clk) begin
        pipe[0] <= (avm_read && !avm_waitrequest) ? in_port : $urandom;
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign avm_readdata = pipe[RL-1];

    always @(negedge clk) begin
        if (avm_read === 1'b1) begin
            if (!in_req) begin
                in_req     = 1;
                stall_left = stall_rand ? int'($urandom_range(0, 2)) : stall_cfg;
            end
            avm_waitrequest = (stall_left > 0);
            if (stall_left > 0) stall_left--;
        end else begin
            in_req          = 0;
            avm_waitrequest = 1'($urandom_range(0, 1));
        end
    end

    // Reference model: reads are tracked by due cycle, changes go to the scoreboard queue.
    int          due_q[$];
    logic [31:0] val_q[$];
    logic [31:0] exp_q[$];
    int          m_cyc   = 0;
    bit          m_first = 1;
    logic [31:0] m_last  = 0;
    bit          m_valid = 0;
    logic [31:0] m_data  = 0;
    bit          m_ovr   = 0;
    bit          m_pulse = 0;
    bit          m_cap;
    bit          m_chg;
    bit          m_hs;
    logic [31:0] m_v;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            due_q.delete();
            val_q.delete();
            exp_q.delete();
            m_first = 1; m_last = 0; m_valid = 0; m_data = 0; m_ovr = 0; m_pulse = 0;
        end else begin
            m_cyc++;
            m_cap = 0;
            m_v   = 0;
            if (due_q.size() > 0 && due_q[0] == m_cyc) begin
                m_cap = 1;
                m_v   = val_q.pop_front();
                void'(due_q.pop_front());
            end
            if (avm_read && !avm_waitrequest) begin
                due_q.push_back(m_cyc + RL);
                val_q.push_back(in_port);
            end
            m_hs    = m_valid && smp_ready;
            m_chg   = m_cap && (m_first || m_v != m_last);
            m_pulse = m_chg;
            if (m_chg && m_valid && !m_hs) m_ovr = 1;
            else if (overrun_clr) m_ovr = 0;
            if (m_chg) begin
                m_first = 0;
                m_last  = m_v;
                m_data  = m_v;
                m_valid = 1;
                exp_q.push_back(m_v);
            end else if (m_hs) begin
                m_valid = 0;
            end
        end
    end

    // Monitor: compares every cycle, pops the scoreboard whenever the DUT announces a change.
    always @(negedge clk) begin
        checkOutput("change_pulse", change_pulse, m_pulse);
        if (change_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL sb_pulse: got change_pulse with data %0h, expected no change", smp_data);
            end else begin
                checkOutput("sb_data", smp_data, exp_q.pop_front());
            end
        end
        checkOutput("smp_valid", smp_valid, m_valid);
        if (m_valid) checkOutput("smp_data", smp_data, m_data);
        checkOutput("overrun", overrun, m_ovr);
        checkOutput("avm_address", avm_address, 32'(POLL_ADDR));
    end

    task automatic waitRise(output int c);
        int n = 0;
        while (avm_read !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        while (avm_read !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            checkCount++;
            $display("[TB] FAIL wait_rise: avm_read low, expected a request within 100 cycles");
        end
        c = tb_cyc;
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        if ($urandom_range(0, 7) == 0) in_port = $urandom_range(0, 3);
        smp_ready   = 1'($urandom_range(0, 1));
        overrun_clr = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 63) == 0) enable = ~enable;
        else if ($urandom_range(0, 15) == 0) enable = 1'b1;
    endtask

    int c1, c2, cnt;

    initial begin
        reset_n = 0; enable = 0; in_port = 0; smp_ready = 0; overrun_clr = 0;
        avm_waitrequest = 0;
        repeat (3) @(negedge clk);
        checkOutput("reset_avm_read", avm_read, 0);
        reset_n = 1; enable = 1;
        @(negedge clk);
        checkOutput("first_req", avm_read, 1);

        // first sample of 0 is reported as a change
        repeat (PERIOD) @(negedge clk);
        checkOutput("first_valid", smp_valid, 1);
        checkOutput("first_data", smp_data, 0);

        // request spacing and a 0->1 change with the consumer always ready
        smp_ready = 1;
        waitRise(c1);
        waitRise(c2);
        checkOutput("req_spacing", c2 - c1, PERIOD);
        in_port = 1;
        repeat (2 * PERIOD) @(negedge clk);
        checkOutput("change_data", smp_data, 1);

        // overrun: two changes with nobody consuming, then clear, then set-wins
        smp_ready = 0;
        in_port = 5;
        repeat (PERIOD + 2) @(negedge clk);
        in_port = 9;
        repeat (PERIOD + 2) @(negedge clk);
        checkOutput("ovr_data", smp_data, 9);
        checkOutput("ovr_flag", overrun, 1);
        overrun_clr = 1;
        @(negedge clk);
        overrun_clr = 0;
        checkOutput("ovr_clr", overrun, 0);
        overrun_clr = 1;
        in_port = 3;
        repeat (2 * PERIOD) @(negedge clk);
        overrun_clr = 0;
        smp_ready = 1;

        // waitrequest stall of three cycles stretches the request to four
        stall_cfg = 3;
        in_port = 6;
        waitRise(c1);
        cnt = 1;
        while (avm_read === 1'b1 && cnt < 20) begin
            @(negedge clk);
            if (avm_read === 1'b1) cnt++;
        end
        checkOutput("stall_len", cnt, 4);
        stall_cfg = 0;

        // enable drop during the read still completes the capture, then stays idle
        in_port = 7;
        waitRise(c1);
        cnt = 0;
        while (avm_read === 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
        enable = 0;
        cnt = 0;
        repeat (4 * PERIOD) begin
            @(negedge clk);
            if (avm_read === 1'b1) cnt++;
        end
        checkOutput("idle_no_req", cnt, 0);
        checkOutput("drop_data", smp_data, 7);

        // reset in the middle of a read
        enable = 1;
        waitRise(c1);
        while (avm_read === 1'b1) @(negedge clk);
        #2 reset_n = 0;
        #1;
        checkOutput("rst_avm_read", avm_read, 0);
        checkOutput("rst_smp_data", smp_data, 0);
        checkOutput("rst_smp_valid", smp_valid, 0);
        checkOutput("rst_pulse", change_pulse, 0);
        checkOutput("rst_overrun", overrun, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        checkOutput("rst_first_req", avm_read, 1);

        // randomised traffic with random stalls
        stall_rand = 1;
        repeat (1500) applyStimulus();
        enable = 0;
        repeat (2 * PERIOD) @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
